pwm_ramp_driver: RTL

//  Motor PWM stage driven by the speed-mode FSM: converts a 0..4 speed level into a
//  PWM output whose duty ramps (soft start/stop) toward the target, one step per PWM

---
 rtl/pwm_ramp_driver_if.sv | 50 +++++
 rtl/pwm_ramp_driver.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_driver_if.sv
// pwm_ramp_driver_if
//   Bundles the speed-level input and the PWM outputs of pwm_ramp_driver.
//   Parameter CNT_WIDTH sizes the duty and target fields.
//   Optional macro PWM_RAMP_BRAKE_EN adds the i_brake signal.
//
//   i_level      level  3 bits   target speed level 0..4 (5..7 mean 0)
//   i_brake      level  1 bit    immediate stop (PWM_RAMP_BRAKE_EN only)
//   o_pwm        out    1 bit    registered motor PWM
//   o_duty       out    CNT_WIDTH  applied duty, ticks high per period
//   o_busy       out    1 bit    ramping up or down
//   o_period_end out    1 bit    one-cycle pulse after the last tick of a period
//   state_dbg    out    2 bits   ramp FSM state (debug)
//   target_dbg   out    CNT_WIDTH  latched target duty (debug)
//
//   There is no valid/ready handshake on this bus: i_level (and i_brake) are
//   plain level signals; i_level is only looked at on the period wrap.
interface pwm_ramp_driver_if #(
  parameter int CNT_WIDTH = 10
);
  logic [2:0]           i_level;
`ifdef PWM_RAMP_BRAKE_EN
  logic                 i_brake;
`endif
  logic                 o_pwm;
  logic [CNT_WIDTH-1:0] o_duty;
  logic                 o_busy;
  logic                 o_period_end;
  logic [1:0]           state_dbg;
  logic [CNT_WIDTH-1:0] target_dbg;

`ifdef PWM_RAMP_BRAKE_EN
  modport master (
    output i_level, i_brake,
    input  o_pwm, o_duty, o_busy, o_period_end, state_dbg, target_dbg
  );
  modport slave (
    input  i_level, i_brake,
    output o_pwm, o_duty, o_busy, o_period_end, state_dbg, target_dbg
  );
`else
  modport master (
    output i_level,
    input  o_pwm, o_duty, o_busy, o_period_end, state_dbg, target_dbg
  );
  modport slave (
    input  i_level,
    output o_pwm, o_duty, o_busy, o_period_end, state_dbg, target_dbg
  );
`endif
endinterface

// File: rtl/pwm_ramp_driver.sv
// pwm_ramp_driver
//   Motor PWM stage with soft start/stop. A prescaler produces counter ticks,
//   the period counter runs 0..PERIOD-1, and at each period wrap the duty
//   moves by at most RAMP_STEP toward the target chosen by the speed level.
//   o_pwm is (cnt < duty), registered one clock behind the counter.
//
//   Ports: i_clk (rising edge), i_reset (async, active-high), bus (slave
//   modport of pwm_ramp_driver_if, see that file for the signal list).
//   Optional macro PWM_RAMP_BRAKE_EN: i_brake forces duty/target to 0 and the
//   FSM to IDLE on the next clock, overriding a simultaneous wrap update.
module pwm_ramp_driver #(
  parameter int CNT_WIDTH = 10,
  parameter int PRESCALE  = 100,
  parameter int PERIOD    = 1000,
  parameter int RAMP_STEP = 50
) (
  input  logic           i_clk,
  input  logic           i_reset,
  pwm_ramp_driver_if.slave bus
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [CNT_WIDTH-1:0] T1 = CNT_WIDTH'(PERIOD / 4);
  localparam logic [CNT_WIDTH-1:0] T2 = CNT_WIDTH'(PERIOD / 2);
  localparam logic [CNT_WIDTH-1:0] T3 = CNT_WIDTH'((3 * PERIOD) / 4);
  localparam logic [CNT_WIDTH-1:0] T4 = CNT_WIDTH'(PERIOD);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PERIOD - 1);
  localparam logic [CNT_WIDTH:0]   STEP_W = (CNT_WIDTH + 1)'(RAMP_STEP);
  localparam logic [PW-1:0]        PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_RAMP_UP   = 2'd1;
  localparam logic [1:0] S_RAMP_DOWN = 2'd2;
  localparam logic [1:0] S_HOLD      = 2'd3;

  logic [PW-1:0]        presc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] duty;
  logic [CNT_WIDTH-1:0] target;
  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 tick;
  logic                 wrap;
  logic                 brake;
  logic                 busy;
  logic [CNT_WIDTH-1:0] level_target;
  logic [CNT_WIDTH-1:0] duty_calc;
  logic [CNT_WIDTH:0]   duty_w;
  logic [CNT_WIDTH:0]   tgt_w;
  logic [CNT_WIDTH:0]   up_sum;
  logic [CNT_WIDTH:0]   dn_diff;
  logic [CNT_WIDTH:0]   dn_limit;

`ifdef PWM_RAMP_BRAKE_EN
  assign brake = bus.i_brake;
`else
  assign brake = 1'b0;
`endif

  assign tick = (presc == PRESC_LAST);
  assign wrap = tick && (cnt == CNT_LAST);

  // Speed level to target duty; unused codes 5..7 stop the motor.
  always_comb begin
    level_target = '0;
    case (bus.i_level)
      3'd1:    level_target = T1;
      3'd2:    level_target = T2;
      3'd3:    level_target = T3;
      3'd4:    level_target = T4;
      default: level_target = '0;
    endcase
  end

  // One ramp step toward the new target, one bit wider so duty+step cannot
  // wrap and the downward step clamps at the target instead of undershooting.
  always_comb begin
    duty_w    = {1'b0, duty};
    tgt_w     = {1'b0, level_target};
    up_sum    = duty_w + STEP_W;
    dn_diff   = duty_w - STEP_W;
    dn_limit  = tgt_w + STEP_W;
    duty_calc = duty;
    if (duty_w < tgt_w) begin
      duty_calc = (up_sum > tgt_w) ? level_target : up_sum[CNT_WIDTH-1:0];
    end else if (duty_w > tgt_w) begin
      duty_calc = (duty_w > dn_limit) ? dn_diff[CNT_WIDTH-1:0] : level_target;
    end
  end

  // Prescaler and period counter keep running through brake.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      presc <= '0;
      cnt   <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (wrap)      cnt <= '0;
      else if (tick) cnt <= cnt + 1'b1;
    end
  end

  // Duty and target move only at the wrap; brake wins over the wrap.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      duty   <= '0;
      target <= '0;
    end else if (brake) begin
      duty   <= '0;
      target <= '0;
    end else if (wrap) begin
      duty   <= duty_calc;
      target <= level_target;
    end
  end

  // o_pwm compares against the duty in force for this period, so a new
  // duty latched at the wrap takes effect exactly from cnt==0.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bus.o_pwm        <= 1'b0;
      bus.o_period_end <= 1'b0;
    end else begin
      bus.o_pwm        <= brake ? 1'b0 : (cnt < duty);
      bus.o_period_end <= wrap;
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= S_IDLE;
    else         state <= state_next;
  end

  // FSM: next state, classified from the post-update duty and target
  always_comb begin
    state_next = state;
    if (brake) begin
      state_next = S_IDLE;
    end else if (wrap) begin
      if (duty_calc < level_target)      state_next = S_RAMP_UP;
      else if (duty_calc > level_target) state_next = S_RAMP_DOWN;
      else if (duty_calc == '0)          state_next = S_IDLE;
      else                               state_next = S_HOLD;
    end
  end

  // FSM: outputs
  always_comb begin
    busy = 1'b0;
    if ((state == S_RAMP_UP) || (state == S_RAMP_DOWN)) busy = 1'b1;
  end

  assign bus.o_busy     = busy;
  assign bus.o_duty     = duty;
  assign bus.state_dbg  = state;
  assign bus.target_dbg = target;
endmodule
